// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: valid/ready imem requests, in-order prefetch queue,
// redirect with squash of in-flight responses, fault halt and ebreak/ecall tags.
module ifu_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  output logic            inst_is_ebreak,
  output logic            inst_is_ecall
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;

  logic [XLEN-1:0]             r_fetch_pc, r_rsp_pc;
  logic [DEPTH-1:0][31:0]      r_data;
  logic [DEPTH-1:0][XLEN-1:0]  r_pc;
  logic [DEPTH-1:0]            r_err;
  logic [AW-1:0]               r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]               r_count, r_inflight, r_drop_cnt;
  logic                        r_halted;

  logic [SW-1:0]   w_credit_sum, w_outstanding, w_redir_drop;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_req_valid, w_req_fire, w_rsp_drop, w_push, w_inst_valid, w_pop;

  // Every request holds a slot until its response is either queued or discarded,
  // so a response can never find the queue full.
  assign w_credit_sum  = SW'(r_count) + SW'(r_inflight) + SW'(r_drop_cnt);
  assign w_outstanding = SW'(r_drop_cnt) + SW'(r_inflight);
  assign w_redir_drop  = (imem_rsp_valid && w_outstanding != '0) ? w_outstanding - SW'(1)
                                                                 : w_outstanding;
  assign w_redir_pc    = redirect_pc & ~XLEN'(3);

  assign w_req_valid  = rstn & ~r_halted & ~redirect_valid & (w_credit_sum < SW'(DEPTH));
  assign w_req_fire   = w_req_valid & imem_req_ready;
  assign w_rsp_drop   = imem_rsp_valid & (r_drop_cnt != '0);
  assign w_push       = imem_rsp_valid & (r_drop_cnt == '0) & (r_inflight != '0) & ~redirect_valid;
  assign w_inst_valid = rstn & ~redirect_valid & (r_count != '0);
  assign w_pop        = w_inst_valid & inst_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_halted   <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redir_pc;
      r_rsp_pc   <= w_redir_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop_cnt <= CW'(w_redir_drop);
      r_halted   <= 1'b0;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + XLEN'(4);
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (imem_rsp_err) r_halted <= 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_push);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= imem_rsp_data;
      r_pc[r_wr_ptr]   <= r_rsp_pc;
      r_err[r_wr_ptr]  <= imem_rsp_err;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = rstn ? r_fetch_pc : '0;
  assign inst_valid     = w_inst_valid;
  assign inst_data      = rstn ? r_data[r_rd_ptr] : '0;
  assign inst_pc        = rstn ? r_pc[r_rd_ptr] : '0;
  assign inst_err       = rstn & r_err[r_rd_ptr];
  assign inst_is_ebreak = w_inst_valid & (r_data[r_rd_ptr] == 32'h0010_0073);
  assign inst_is_ecall  = w_inst_valid & (r_data[r_rd_ptr] == 32'h0000_0073);

  // A response with nothing outstanding is a memory-side protocol violation.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rstn)
    !(imem_rsp_valid && r_inflight == '0 && r_drop_cnt == '0));
endmodule
